// File: rtl/wb_arbiter_2to1.sv
// ============================================================================
// wb_arbiter_2to1 : round-robin 2-master Wishbone pipelined arbiter, 1 slave.
// Optional watchdog: WB_ARB_TIMEOUT_EN.                          Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_arbiter_2to1 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_we_i,
    input  logic [31:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    input  logic [3:0]  m0_wb_sel_i,
    output logic        m0_wb_stall_o,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_err_o,
    output logic [31:0] m0_wb_dat_o,
    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_we_i,
    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    input  logic [3:0]  m1_wb_sel_i,
    output logic        m1_wb_stall_o,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_err_o,
    output logic [31:0] m1_wb_dat_o,
    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_we_o,
    output logic [31:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    output logic [3:0]  s_wb_sel_o,
    input  logic        s_wb_stall_i,
    input  logic        s_wb_ack_i,
    input  logic        s_wb_err_i,
    input  logic [31:0] s_wb_dat_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state;
    logic       last;
    logic [1:0] outstanding;
    logic [1:0] outstanding_next;
    logic       sel0;
    logic       sel1;
    logic       full;
    logic       accept;
    logic       resp;
    logic       timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    assign sel0   = (state == GNT0);
    assign sel1   = (state == GNT1);
    assign full   = (outstanding == 2'd3);
    assign accept = s_wb_stb_o & ~s_wb_stall_i;
    assign resp   = (sel0 | sel1) & (s_wb_ack_i | s_wb_err_i);

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_run;

    assign wd_run  = (sel0 | sel1) & (outstanding != 2'd0) & ~s_wb_ack_i & ~s_wb_err_i;
    assign timeout = wd_run & (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wd_cnt <= 16'd0;
        end else if (wd_run && !timeout) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= 16'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Request mux; a full pipeline or a firing watchdog keeps the strobe off the slave.
    always_comb begin
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        s_wb_we_o  = 1'b0;
        s_wb_adr_o = 32'd0;
        s_wb_dat_o = 32'd0;
        s_wb_sel_o = 4'd0;
        if (sel0) begin
            s_wb_cyc_o = m0_wb_cyc_i & ~timeout;
            s_wb_stb_o = m0_wb_stb_i & ~full & ~timeout;
            s_wb_we_o  = m0_wb_we_i;
            s_wb_adr_o = m0_wb_adr_i;
            s_wb_dat_o = m0_wb_dat_i;
            s_wb_sel_o = m0_wb_sel_i;
        end else if (sel1) begin
            s_wb_cyc_o = m1_wb_cyc_i & ~timeout;
            s_wb_stb_o = m1_wb_stb_i & ~full & ~timeout;
            s_wb_we_o  = m1_wb_we_i;
            s_wb_adr_o = m1_wb_adr_i;
            s_wb_dat_o = m1_wb_dat_i;
            s_wb_sel_o = m1_wb_sel_i;
        end
    end

    assign m0_wb_stall_o = ~sel0 | s_wb_stall_i | full | timeout;
    assign m0_wb_ack_o   = sel0 & s_wb_ack_i;
    assign m0_wb_err_o   = sel0 & (s_wb_err_i | timeout);
    assign m0_wb_dat_o   = sel0 ? s_wb_dat_i : 32'd0;

    assign m1_wb_stall_o = ~sel1 | s_wb_stall_i | full | timeout;
    assign m1_wb_ack_o   = sel1 & s_wb_ack_i;
    assign m1_wb_err_o   = sel1 & (s_wb_err_i | timeout);
    assign m1_wb_dat_o   = sel1 ? s_wb_dat_i : 32'd0;

    assign grant_o = {sel1, sel0};

    always_comb begin
        outstanding_next = outstanding;
        if (accept && !resp && !full) begin
            outstanding_next = outstanding + 2'd1;
        end else if (resp && !accept && outstanding != 2'd0) begin
            outstanding_next = outstanding - 2'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state       <= IDLE;
            last        <= 1'b1;
            outstanding <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding <= 2'd0;
                    if (m0_wb_cyc_i && (!m1_wb_cyc_i || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_wb_cyc_i) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!m0_wb_cyc_i || timeout) begin
                        state       <= IDLE;
                        outstanding <= 2'd0;
                    end else begin
                        outstanding <= outstanding_next;
                    end
                end
                GNT1: begin
                    if (!m1_wb_cyc_i || timeout) begin
                        state       <= IDLE;
                        outstanding <= 2'd0;
                    end else begin
                        outstanding <= outstanding_next;
                    end
                end
                default: begin
                    state       <= IDLE;
                    outstanding <= 2'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
